// File: rtl/hist_pkg.sv
// Shared definitions for the histogram engine: FSM state encoding and
// fixed pipeline timing constants. Size-dependent constants (bin count,
// counter ceiling) live in the modules because they follow the parameters.
package hist_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ACCUM = 3'd2,
        ST_FLUSH = 3'd3,
        ST_COPY  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Extra COPY cycle needed because accumulator reads return one cycle late.
    localparam int COPY_LAT  = 1;
    // Cycles after the last pixel until its read-modify-write has committed.
    localparam int FLUSH_CYC = 2;

endpackage

// File: rtl/dp_bram.sv
// Simple dual-port block RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old data.
module dp_bram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    // NOTE: the array is deliberately not reset; contents are cleared by a sweep
    // so the memory still maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            // NOTE: non-blocking assignment for all clocked state, so every
            // register samples pre-edge values regardless of block order.
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; only the output register is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/hist_rmw_pipe.sv
// Read-modify-write pipeline for the bin accumulator.
// Stage 0 issues the read, stage 1 receives RAM data and computes the
// saturating increment, stage 2 commits the write. A copy of the last
// committed write (stage 3) covers the same-bin hazard at distance 2.
module hist_rmw_pipe #(
    parameter int BIN_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [BIN_W-1:0] in_bin,
    output logic [BIN_W-1:0] ram_raddr,
    input  logic [CNT_W-1:0] ram_rdata,
    output logic             wr_en,
    output logic [BIN_W-1:0] wr_addr,
    output logic [CNT_W-1:0] wr_data,
    output logic             sat_hit
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             s1_valid, s2_valid, s3_valid;
    logic [BIN_W-1:0] s1_addr, s2_addr, s3_addr;
    logic [CNT_W-1:0] s2_data, s3_data;
    logic [CNT_W-1:0] old_cnt, new_cnt;

    assign ram_raddr = in_bin;

    // Pick the freshest copy of the bin: write stage, then last commit, then RAM.
    always_comb begin
        // NOTE: default assignments first so no path leaves a variable unassigned
        // and no latch is inferred.
        old_cnt = ram_rdata;
        if (s2_valid && (s2_addr == s1_addr)) begin
            old_cnt = s2_data;
        end else if (s3_valid && (s3_addr == s1_addr)) begin
            old_cnt = s3_data;
        end
        new_cnt = (old_cnt == CNT_MAX) ? old_cnt : old_cnt + CNT_W'(1);
    end

    // Advance the pipeline; only the valid bits need a reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            s1_addr  <= in_bin;
            s2_valid <= s1_valid;
            s2_addr  <= s1_addr;
            s2_data  <= new_cnt;
            s3_valid <= s2_valid;
            s3_addr  <= s2_addr;
            s3_data  <= s2_data;
        end
    end

    assign wr_en   = s2_valid;
    assign wr_addr = s2_addr;
    assign wr_data = s2_data;
    assign sat_hit = s2_valid && (s2_data == CNT_MAX);

endmodule

// File: rtl/histogram_engine.sv
// Frame histogram engine: bins a pixel stream into 2^BIN_W saturating
// counters, then copies and clears the accumulator into the back half of a
// double-buffered readout bank and swaps banks.
// Optional feature macro: HIST_PEAK_EN (adds peak_bin/peak_cnt outputs).
module histogram_engine
    import hist_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int BIN_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_valid,
    input  logic             end_of_frame,
    input  logic             calc_flag,
    input  logic [BIN_W-1:0] rd_addr,
    output logic [CNT_W-1:0] rd_data,
    output logic             out_valid,
    output logic             busy,
    output logic             saturated,
    output logic             overrun
`ifdef HIST_PEAK_EN
    ,
    output logic [BIN_W-1:0] peak_bin,
    output logic [CNT_W-1:0] peak_cnt
`endif
);

    localparam int NBINS = 1 << BIN_W;
    localparam int IDX_W = BIN_W + 1;
    localparam logic [IDX_W-1:0] CLEAR_LAST = IDX_W'(NBINS - 1);
    localparam logic [IDX_W-1:0] FLUSH_LAST = IDX_W'(FLUSH_CYC - 1);
    localparam logic [IDX_W-1:0] COPY_LAST  = IDX_W'(NBINS - 1 + COPY_LAT);

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic             bank_sel;

    logic             pix_accept;
    logic [BIN_W-1:0] pix_bin;
    logic             clearing;
    logic             copy_wr;
    logic [BIN_W-1:0] copy_addr;

    logic [BIN_W-1:0] pipe_raddr, pipe_waddr;
    logic             pipe_we, pipe_sat;
    logic [CNT_W-1:0] pipe_wdata;

    logic             acc_we;
    logic [BIN_W-1:0] acc_waddr, acc_raddr;
    logic [CNT_W-1:0] acc_wdata, acc_rdata;

    logic             bank0_we, bank1_we;
    logic [BIN_W-1:0] bank_waddr;
    logic [CNT_W-1:0] bank_wdata, bank0_q, bank1_q;

    assign pix_bin    = in_pixel[PIX_W-1 -: BIN_W];
    assign pix_accept = (state == ST_ACCUM) && in_valid;
    assign clearing   = (state == ST_CLEAR);
    // COPY index i reads accumulator[i]; the data lands one cycle later for i-1.
    assign copy_wr    = (state == ST_COPY) && (idx != '0);
    assign copy_addr  = idx[BIN_W-1:0] - BIN_W'(1);

    // State and sweep-index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Next-state logic; idx is the sweep counter for CLEAR, FLUSH and COPY.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            ST_CLEAR: begin
                idx_next = idx + IDX_W'(1);
                if (idx == CLEAR_LAST) begin
                    state_next = ST_IDLE;
                    idx_next   = '0;
                end
            end
            ST_IDLE: begin
                if (calc_flag) begin
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid && end_of_frame) begin
                    state_next = ST_FLUSH;
                    idx_next   = '0;
                end
            end
            ST_FLUSH: begin
                idx_next = idx + IDX_W'(1);
                if (idx == FLUSH_LAST) begin
                    state_next = ST_COPY;
                    idx_next   = '0;
                end
            end
            ST_COPY: begin
                idx_next = idx + IDX_W'(1);
                if (idx == COPY_LAST) begin
                    state_next = ST_DONE;
                    idx_next   = '0;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_CLEAR;
                idx_next   = '0;
            end
        endcase
    end

    hist_rmw_pipe #(
        .BIN_W (BIN_W),
        .CNT_W (CNT_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (pix_accept),
        .in_bin    (pix_bin),
        .ram_raddr (pipe_raddr),
        .ram_rdata (acc_rdata),
        .wr_en     (pipe_we),
        .wr_addr   (pipe_waddr),
        .wr_data   (pipe_wdata),
        .sat_hit   (pipe_sat)
    );

    // Accumulator port ownership: sweep in CLEAR/COPY, RMW pipe otherwise.
    always_comb begin
        acc_we    = pipe_we;
        acc_waddr = pipe_waddr;
        acc_wdata = pipe_wdata;
        acc_raddr = pipe_raddr;
        case (state)
            ST_CLEAR: begin
                acc_we    = 1'b1;
                acc_waddr = idx[BIN_W-1:0];
                acc_wdata = '0;
            end
            ST_COPY: begin
                acc_raddr = idx[BIN_W-1:0];
                acc_we    = copy_wr;
                acc_waddr = copy_addr;
                acc_wdata = '0;
            end
            default: ;
        endcase
    end

    // CLEAR zeroes both banks; COPY fills only the back bank.
    assign bank_waddr = clearing ? idx[BIN_W-1:0] : copy_addr;
    assign bank_wdata = clearing ? '0 : acc_rdata;
    assign bank0_we   = clearing || (copy_wr && bank_sel);
    assign bank1_we   = clearing || (copy_wr && !bank_sel);

    dp_bram #(.DEPTH(NBINS), .WIDTH(CNT_W)) u_acc (
        .clk   (clk),
        .rst   (rst),
        .we    (acc_we),
        .waddr (acc_waddr),
        .wdata (acc_wdata),
        .raddr (acc_raddr),
        .rdata (acc_rdata)
    );

    dp_bram #(.DEPTH(NBINS), .WIDTH(CNT_W)) u_bank0 (
        .clk   (clk),
        .rst   (rst),
        .we    (bank0_we),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .raddr (rd_addr),
        .rdata (bank0_q)
    );

    dp_bram #(.DEPTH(NBINS), .WIDTH(CNT_W)) u_bank1 (
        .clk   (clk),
        .rst   (rst),
        .we    (bank1_we),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .raddr (rd_addr),
        .rdata (bank1_q)
    );

    // Both banks are read every cycle; the select is the bank_sel in force when
    // the data appears, so a read issued in DONE already sees the new bank.
    assign rd_data   = bank_sel ? bank1_q : bank0_q;
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Bank swap and sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_sel  <= 1'b0;
            saturated <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (state == ST_DONE) begin
                bank_sel <= ~bank_sel;
            end
            if ((state == ST_IDLE) && calc_flag) begin
                saturated <= 1'b0;
                overrun   <= 1'b0;
            end else begin
                if (pipe_sat) begin
                    saturated <= 1'b1;
                end
                if (in_valid && ((state == ST_FLUSH) || (state == ST_COPY) ||
                                 (state == ST_DONE))) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

`ifdef HIST_PEAK_EN
    logic [BIN_W-1:0] run_bin;
    logic [CNT_W-1:0] run_cnt;

    // Track the largest copied count; strict compare keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_bin  <= '0;
            run_cnt  <= '0;
            peak_bin <= '0;
            peak_cnt <= '0;
        end else begin
            if (state == ST_FLUSH) begin
                run_bin <= '0;
                run_cnt <= '0;
            end else if (copy_wr && (acc_rdata > run_cnt)) begin
                run_bin <= copy_addr;
                run_cnt <= acc_rdata;
            end
            if (state == ST_DONE) begin
                peak_bin <= run_bin;
                peak_cnt <= run_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_histogram_engine.sv
// Self-checking bench for histogram_engine: a 16-bit-counter instance for the
// main scenarios and a 4-bit-counter instance for saturation.
module tb_histogram_engine;

    localparam int N = 256;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  in_pixel;
    logic        in_valid, end_of_frame, calc_flag;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic        out_valid, busy, saturated, overrun;

    logic [7:0]  s_pixel;
    logic        s_valid, s_eof, s_calc;
    logic [7:0]  s_rd_addr;
    logic [3:0]  s_rd_data;
    logic        s_out_valid, s_busy, s_saturated, s_overrun;

`ifdef HIST_PEAK_EN
    logic [7:0]  peak_bin, s_peak_bin;
    logic [15:0] peak_cnt;
    logic [3:0]  s_peak_cnt;
`endif

    histogram_engine #(.PIX_W(8), .BIN_W(8), .CNT_W(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .in_pixel     (in_pixel),
        .in_valid     (in_valid),
        .end_of_frame (end_of_frame),
        .calc_flag    (calc_flag),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .out_valid    (out_valid),
        .busy         (busy),
        .saturated    (saturated),
        .overrun      (overrun)
`ifdef HIST_PEAK_EN
        ,
        .peak_bin     (peak_bin),
        .peak_cnt     (peak_cnt)
`endif
    );

    histogram_engine #(.PIX_W(8), .BIN_W(8), .CNT_W(4)) u_sat (
        .clk          (clk),
        .rst          (rst),
        .in_pixel     (s_pixel),
        .in_valid     (s_valid),
        .end_of_frame (s_eof),
        .calc_flag    (s_calc),
        .rd_addr      (s_rd_addr),
        .rd_data      (s_rd_data),
        .out_valid    (s_out_valid),
        .busy         (s_busy),
        .saturated    (s_saturated),
        .overrun      (s_overrun)
`ifdef HIST_PEAK_EN
        ,
        .peak_bin     (s_peak_bin),
        .peak_cnt     (s_peak_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int acc_m   [N];
    int front_m [N];
    int exp_q   [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop the scoreboard entry for the read that just returned.
    task automatic check_rd(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s: observed=%0h expected=<scoreboard empty>", tag, obs);
        end else begin
            check(tag, obs, exp_q.pop_front());
        end
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < N; a++) begin
            rd_addr = 8'(a);
            exp_q.push_back(front_m[a]);
            tick();
            check_rd(tag, rd_data);
        end
    endtask

    task automatic wait_idle(output int cycles, output int valids);
        cycles = 0;
        valids = 0;
        while (busy !== 1'b0 && cycles < 2000) begin
            tick();
            cycles++;
            if (out_valid === 1'b1) valids++;
        end
    endtask

    task automatic arm();
        calc_flag = 1'b1;
        tick();
        calc_flag = 1'b0;
        for (int i = 0; i < N; i++) acc_m[i] = 0;
        check("arm_busy", busy, 1'b1);
        check("arm_sat_clr", saturated, 1'b0);
        check("arm_ovr_clr", overrun, 1'b0);
    endtask

    task automatic send(input logic [7:0] p, input bit eof, input int gap);
        in_pixel     = p;
        in_valid     = 1'b1;
        end_of_frame = eof;
        acc_m[p]++;
        tick();
        in_valid     = 1'b0;
        end_of_frame = 1'b0;
        repeat (gap) tick();
    endtask

    // Called in cycle 1 after the EOF pixel; reads the old bank until DONE,
    // then checks the pulse timing and that a DONE-cycle read sees the new bank.
    task automatic wait_done(input string tag, input int probe);
        int c;
        c = 1;
        while (out_valid !== 1'b1 && c < N + 20) begin
            rd_addr = 8'(c);
            exp_q.push_back(front_m[c % N]);
            tick();
            c++;
            check_rd({tag, "_old_rd"}, rd_data);
        end
        check({tag, "_latency"}, c, N + 4);
        front_m = acc_m;
        rd_addr = 8'(probe);
        exp_q.push_back(front_m[probe]);
        tick();
        check_rd({tag, "_done_rd"}, rd_data);
        check({tag, "_pulse"}, out_valid, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int cyc, nval;
        logic [7:0] pix3 [12];
        int         gap3 [12];
        logic [7:0] pixb [6];

        pix3 = '{8'h01, 8'h02, 8'h01, 8'h01, 8'h03, 8'h03, 8'h04, 8'h03, 8'h01, 8'h02, 8'h01, 8'h03};
        gap3 = '{0, 0, 1, 0, 0, 1, 2, 0, 0, 2, 1, 0};
        pixb = '{8'h07, 8'h07, 8'h02, 8'h07, 8'h09, 8'h09};

        rst = 1'b1;
        in_pixel = '0; in_valid = 1'b0; end_of_frame = 1'b0; calc_flag = 1'b0; rd_addr = '0;
        s_pixel = '0; s_valid = 1'b0; s_eof = 1'b0; s_calc = 1'b0; s_rd_addr = '0;
        for (int i = 0; i < N; i++) begin
            acc_m[i] = 0;
            front_m[i] = 0;
        end

        // 1. Reset state, CLEAR sweep length, all bins zero.
        repeat (3) tick();
        check("rst_busy", busy, 1'b1);
        check("rst_valid", out_valid, 1'b0);
        check("rst_sat", saturated, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_rd", rd_data, 16'h0);
        check("rst_s_rd", s_rd_data, 4'h0);
        rst = 1'b0;
        wait_idle(cyc, nval);
        check("clear_len", cyc, N);
        check("s_clear_done", s_busy, 1'b0);
        read_all("clr_rd");

        // 2. Sixteen back-to-back pixels of one bin.
        arm();
        for (int i = 0; i < 16; i++) send(8'h05, i == 15, 0);
        wait_done("f1", 5);
        read_all("f1_rd");

        // 3. Forwarding at distance 1 and 2 with gaps; IDLE pixels, lone EOF and
        //    calc_flag during ACCUM are all ignored.
        in_pixel = 8'h01; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("idle_pix_ovr", overrun, 1'b0);
        arm();
        for (int i = 0; i < 12; i++) begin
            if (i == 6) begin
                end_of_frame = 1'b1;
                calc_flag    = 1'b1;
                tick();
                end_of_frame = 1'b0;
                calc_flag    = 1'b0;
                check("lone_eof_ignored", busy, 1'b1);
            end
            send(pix3[i], i == 11, gap3[i]);
        end
        wait_done("f3", 1);
        read_all("f3_rd");
        check("f3_sat", saturated, 1'b0);
        check("f3_ovr", overrun, 1'b0);

        // 4. Saturation on the 4-bit instance.
        s_calc = 1'b1;
        tick();
        s_calc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_pixel = 8'hFF; s_valid = 1'b1; s_eof = (i == 19);
            tick();
        end
        s_valid = 1'b0; s_eof = 1'b0;
        cyc = 1;
        while (s_out_valid !== 1'b1 && cyc < N + 20) begin
            tick();
            cyc++;
        end
        check("sat_latency", cyc, N + 4);
        tick();
        s_rd_addr = 8'hFF;
        exp_q.push_back(15);
        tick();
        check_rd("sat_bin255", s_rd_data);
        s_rd_addr = 8'h00;
        exp_q.push_back(0);
        tick();
        check_rd("sat_bin0", s_rd_data);
        check("sat_flag", s_saturated, 1'b1);
        s_calc = 1'b1;
        tick();
        s_calc = 1'b0;
        check("sat_flag_clr", s_saturated, 1'b0);

        // 5. Frame B: reads during ACCUM/COPY return frame A, then B with no carry-over.
        arm();
        for (int b = 1; b <= 4; b++) begin
            rd_addr = 8'(b);
            exp_q.push_back(front_m[b]);
            tick();
            check_rd("fb_accum_rd", rd_data);
        end
        for (int i = 0; i < 6; i++) send(pixb[i], i == 5, 0);
        wait_done("fb", 7);
        read_all("fb_rd");

`ifdef HIST_PEAK_EN
        // Peak tie: bins 3 and 7 both reach 9; the lower index wins.
        arm();
        for (int i = 0; i < 18; i++) send((i % 2 == 0) ? 8'h07 : 8'h03, i == 17, 0);
        wait_done("pk", 3);
        check("peak_bin", peak_bin, 8'd3);
        check("peak_cnt", peak_cnt, 16'd9);
`endif

        // 6. Overrun during FLUSH, then reset at COPY index 100.
        arm();
        send(8'h0A, 1'b0, 0);
        send(8'h0A, 1'b1, 0);
        in_pixel = 8'h20; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("flush_overrun", overrun, 1'b1);
        repeat (101) tick();
        check("copy_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", busy, 1'b1);
        check("mid_rst_ovr", overrun, 1'b0);
        wait_idle(cyc, nval);
        check("mid_rst_clear_len", cyc, N);
        check("mid_rst_no_valid", nval, 0);
        for (int i = 0; i < N; i++) front_m[i] = 0;
        read_all("mid_rst_rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
